// File: rtl/matrix_rom_loader_if.sv
// Command, ROM and bank signals shared by matrix_rom_loader and its environment.
// LOADER_STRIDE_EN adds the stride field to the command.
interface matrix_rom_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_DEPTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
`ifdef LOADER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride;
`endif
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  bank_enable;
  logic [BANK_DEPTH-1:0] bank_select;
  logic [DATA_WIDTH-1:0] bank_data;
  logic                  busy;
  logic                  done;

`ifdef LOADER_STRIDE_EN
  modport master (output start, base_addr, stride, rom_data,
                  input  rom_en, rom_addr, bank_enable, bank_select, bank_data, busy, done);
  modport slave  (input  start, base_addr, stride, rom_data,
                  output rom_en, rom_addr, bank_enable, bank_select, bank_data, busy, done);
`else
  modport master (output start, base_addr, rom_data,
                  input  rom_en, rom_addr, bank_enable, bank_select, bank_data, busy, done);
  modport slave  (input  start, base_addr, rom_data,
                  output rom_en, rom_addr, bank_enable, bank_select, bank_data, busy, done);
`endif
endinterface

// File: rtl/matrix_rom_loader.sv
// Reads BANK_DEPTH ROM elements per start and writes them one-hot into a register bank.
// Define LOADER_STRIDE_EN for a per-command address stride (default stride is 1).
module matrix_rom_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_DEPTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic              clk_i,
  input logic              reset_i,   // active low, synchronous
  matrix_rom_loader_if.slave lif
);
  localparam int IDX_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANK_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [IDX_W-1:0]      idx_q, idx_d, tag_q, tag_d, nidx;
  logic [ADDR_WIDTH-1:0] base_q, base_d, rom_addr_q, rom_addr_d, offset;
  logic                  rom_en_q, rom_en_d, busy_q, busy_d, done_q, done_d, accept;
  logic [1:0]            vld_pipe_q, vld_pipe_d;
  logic [BANK_DEPTH-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef LOADER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign accept = lif.start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (idx_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   if (vld_pipe_q[1] && sel_q[BANK_DEPTH-1]) state_d = DONE;
      DONE:    state_d = accept ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read address is precomputed for the next cycle so rom_addr leaves a flop.
  always_comb begin
    nidx   = accept ? '0 : idx_q + IDX_W'(1);
    idx_d  = (accept || state_q == FETCH) ? nidx : idx_q;
    base_d = accept ? lif.base_addr : base_q;
`ifdef LOADER_STRIDE_EN
    stride_d = accept ? lif.stride : stride_q;
    offset   = ADDR_WIDTH'(nidx) * stride_d;
`else
    offset   = ADDR_WIDTH'(nidx);
`endif
    rom_en_d   = accept || (state_q == FETCH && idx_q != LAST_IDX);
    rom_addr_d = rom_en_d ? base_d + offset : '0;
    // Stage 0: ROM data arrives tagged; stage 1: bank write presented.
    tag_d      = idx_q;
    vld_pipe_d = {vld_pipe_q[0], rom_en_q};
    sel_d      = vld_pipe_q[0] ? (BANK_DEPTH'(1) << tag_q) : '0;
    data_d     = vld_pipe_q[0] ? lif.rom_data : '0;
    busy_d     = (state_d == FETCH || state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      idx_q      <= '0;
      tag_q      <= '0;
      base_q     <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      vld_pipe_q <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LOADER_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      base_q     <= base_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      vld_pipe_q <= vld_pipe_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef LOADER_STRIDE_EN
      stride_q   <= stride_d;
`endif
    end
  end

  assign lif.rom_en      = rom_en_q;
  assign lif.rom_addr    = rom_addr_q;
  assign lif.bank_enable = vld_pipe_q[1];
  assign lif.bank_select = sel_q;
  assign lif.bank_data   = data_q;
  assign lif.busy        = busy_q;
  assign lif.done        = done_q;
endmodule

// File: tb/tb_matrix_rom_loader.sv
// Self-checking bench for matrix_rom_loader: cycle table, address/write scoreboard, corner sequences.
module tb_matrix_rom_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_rom_loader_if #(.DATA_WIDTH(8), .BANK_DEPTH(8), .ADDR_WIDTH(8)) bus ();
  matrix_rom_loader #(.DATA_WIDTH(8), .BANK_DEPTH(8), .ADDR_WIDTH(8))
    dut (.clk_i(clk), .reset_i(rst_n), .lif(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // ROM contents: addr ^ 0xA5, one cycle read latency
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= bus.rom_addr ^ 8'hA5;

  // Bank model: ignores writes in a cycle where reset is asserted, never clears on reset
  logic [7:0] bank [8];
  logic [7:0] bank_mask = 8'h00;
  logic       bank_clr = 1'b0;
  int wr_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (bank_clr) bank_mask <= 8'h00;
    else if (rst_n && bus.bank_enable) begin
      for (int j = 0; j < 8; j++)
        if (bus.bank_select[j]) begin
          bank[j]      <= bus.bank_data;
          bank_mask[j] <= 1'b1;
        end
      wr_cnt <= wr_cnt + 1;
    end
    if (rst_n && bus.done) done_cnt <= done_cnt + 1;
  end

  // Scoreboard of expected read addresses and bank writes
  typedef struct packed { logic [7:0] sel; logic [7:0] data; } wr_t;
  logic [7:0] exp_addr[$];
  wr_t        exp_wr[$];
  logic       sb_en = 1'b1;

  task automatic push_exp(input logic [7:0] base, input logic [7:0] str);
    logic [7:0] a;
    logic [7:0] one;
    one = 8'h01;
    for (int k = 0; k < 8; k++) begin
      a = 8'(base + 8'(k) * str);
      exp_addr.push_back(a);
      exp_wr.push_back('{sel: 8'(one << k), data: a ^ 8'hA5});
    end
  endtask

  always @(negedge clk) if (sb_en) begin
    if (bus.rom_en) begin
      if (exp_addr.size() == 0) chk("sb_extra_read", 1, 0);
      else chk("sb_rom_addr", bus.rom_addr, exp_addr.pop_front());
    end
    if (bus.bank_enable) begin
      if (exp_wr.size() == 0) chk("sb_extra_write", 1, 0);
      else chk("sb_bank_write", {bus.bank_select, bus.bank_data}, exp_wr.pop_front());
    end
    chk("sel_onehot", (bus.bank_enable ? $countones(bus.bank_select) == 1
                                       : bus.bank_select == 8'h00), 1);
  end

  task automatic drive_cmd(input logic s, input logic [7:0] base, input logic [7:0] str);
    bus.start     = s;
    bus.base_addr = base;
`ifdef LOADER_STRIDE_EN
    bus.stride    = str;
`else
    if (str != 8'd1) $display("note: stride %0d ignored in this build", str);
`endif
  endtask

  task automatic check_bank(input string name, input logic [7:0] base, input logic [7:0] str);
    chk({name, "_mask"}, bank_mask, 8'hFF);
    for (int j = 0; j < 8; j++)
      chk({name, "_entry"}, bank[j], 8'(base + 8'(j) * str) ^ 8'hA5);
  endtask

  // Starts at the negedge of cycle 0, returns at the negedge of cycle 12 (IDLE)
  task automatic do_load(input string name, input logic [7:0] base, input logic [7:0] str);
    int n;
    drive_cmd(1'b1, base, str);
    push_exp(base, str);
    bank_clr = 1'b1;
    tick();
    drive_cmd(1'b0, 8'h00, 8'd1);
    bank_clr = 1'b0;
    n = 0;
    while (!bus.done && n < 30) begin tick(); n++; end
    chk({name, "_done_cycle"}, 32'(n + 1), 32'd11);
    tick();
    chk({name, "_sb_empty"}, 32'(exp_addr.size() + exp_wr.size()), 0);
    check_bank(name, base, str);
  endtask

  typedef struct {
    logic       start; logic [7:0] base;
    logic       rom_en; logic [7:0] addr; logic ben; logic [7:0] sel; logic [7:0] data;
    logic       busy; logic done;
  } vec_t;
  vec_t vt[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, dn0;
    logic [7:0] one;
    one = 8'h01;
    for (int c = 0; c < 13; c++) begin
      vt[c].start  = (c == 0);
      vt[c].base   = 8'h10;
      vt[c].rom_en = (c >= 1 && c <= 8);
      vt[c].addr   = 8'(8'h10 + c - 1);
      vt[c].ben    = (c >= 3 && c <= 10);
      vt[c].sel    = vt[c].ben ? 8'(one << (c - 3)) : 8'h00;
      vt[c].data   = 8'(8'h10 + c - 3) ^ 8'hA5;
      vt[c].busy   = (c >= 1 && c <= 10);
      vt[c].done   = (c == 11);
    end

    drive_cmd(1'b0, 8'h00, 8'd1);
    tick(3);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_outputs", {bus.bank_enable, bus.bank_select, bus.bank_data, bus.busy, bus.done}, 0);
    rst_n = 1'b1;
    tick();

    // Basic load, cycle-accurate
    for (int c = 0; c < 13; c++) begin
      chk("tbl_rom_en", bus.rom_en, vt[c].rom_en);
      if (vt[c].rom_en) chk("tbl_rom_addr", bus.rom_addr, vt[c].addr);
      chk("tbl_bank_en", bus.bank_enable, vt[c].ben);
      chk("tbl_bank_sel", bus.bank_select, vt[c].sel);
      if (vt[c].ben) chk("tbl_bank_data", bus.bank_data, vt[c].data);
      chk("tbl_busy", bus.busy, vt[c].busy);
      chk("tbl_done", bus.done, vt[c].done);
      drive_cmd(vt[c].start, vt[c].base, 8'd1);
      bank_clr = vt[c].start;
      if (vt[c].start) push_exp(vt[c].base, 8'd1);
      tick();
    end
    chk("tbl_sb_empty", 32'(exp_addr.size() + exp_wr.size()), 0);
    check_bank("tbl_bank", 8'h10, 8'd1);

    // Address wrap
    do_load("wrap", 8'hFE, 8'd1);

    // start pulses in cycles 4 and 9 are ignored
    wr0 = wr_cnt; dn0 = done_cnt;
    drive_cmd(1'b1, 8'h80, 8'd1); push_exp(8'h80, 8'd1); bank_clr = 1'b1;
    tick(); drive_cmd(1'b0, 8'h00, 8'd1); bank_clr = 1'b0;
    tick(3); drive_cmd(1'b1, 8'h99, 8'd1);
    tick(); drive_cmd(1'b0, 8'h00, 8'd1);
    tick(4); drive_cmd(1'b1, 8'h99, 8'd1);
    tick(); drive_cmd(1'b0, 8'h00, 8'd1);
    tick();
    chk("ign_done_c11", bus.done, 1);
    tick();
    chk("ign_idle_c12", {bus.busy, bus.done, bus.rom_en}, 0);
    tick(3);
    chk("ign_write_count", 32'(wr_cnt - wr0), 8);
    chk("ign_done_count", 32'(done_cnt - dn0), 1);
    check_bank("ign_bank", 8'h80, 8'd1);

    // Back-to-back: start held in DONE
    drive_cmd(1'b1, 8'h20, 8'd1); push_exp(8'h20, 8'd1);
    tick(); drive_cmd(1'b0, 8'h00, 8'd1);
    tick(10);
    chk("b2b_done_c11", bus.done, 1);
    drive_cmd(1'b1, 8'h40, 8'd1); push_exp(8'h40, 8'd1); bank_clr = 1'b1;
    tick(); drive_cmd(1'b0, 8'h00, 8'd1); bank_clr = 1'b0;
    chk("b2b_rom_en_c12", bus.rom_en, 1);
    chk("b2b_rom_addr_c12", bus.rom_addr, 8'h40);
    chk("b2b_busy_c12", bus.busy, 1);
    tick(10);
    chk("b2b_done2", bus.done, 1);
    tick();
    chk("b2b_sb_empty", 32'(exp_addr.size() + exp_wr.size()), 0);
    check_bank("b2b_bank", 8'h40, 8'd1);

    // Reset in cycle 6 of a load
    sb_en = 1'b0;
    wr0 = wr_cnt; dn0 = done_cnt;
    drive_cmd(1'b1, 8'h60, 8'd1); bank_clr = 1'b1;
    tick(); drive_cmd(1'b0, 8'h00, 8'd1); bank_clr = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_rom", {bus.rom_en, bus.rom_addr}, 0);
    chk("mid_rst_bank", {bus.bank_enable, bus.bank_select, bus.bank_data}, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    rst_n = 1'b1;
    tick(12);
    chk("mid_rst_idle", {bus.busy, bus.rom_en, bus.bank_enable}, 0);
    chk("mid_rst_writes", 32'(wr_cnt - wr0), 3);
    chk("mid_rst_mask", bank_mask, 8'h07);
    chk("mid_rst_no_done", 32'(done_cnt - dn0), 0);
    for (int j = 0; j < 3; j++) chk("mid_rst_entry", bank[j], 8'(8'h60 + j) ^ 8'hA5);
    sb_en = 1'b1;

`ifdef LOADER_STRIDE_EN
    do_load("stride8", 8'h00, 8'h08);
    do_load("stride30", 8'h00, 8'h30);
`else
    do_load("plain", 8'h5A, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_rom_loader.md
# matrix_rom_loader

Upstream sequencer for the systolic-array register banks. On a start pulse it reads `BANK_DEPTH` consecutive matrix elements from a synchronous ROM. It then writes each element into the 8-byte register bank by driving the bank's write enable, a one-hot select and the data byte. It reports busy and done to the array controller, so one loader instance fills one bank (one matrix row or column) per command.

## Interface
- `DATA_WIDTH`, 8, element width; equals the bank data width.
- `BANK_DEPTH`, 8, number of bank entries; also the width of the one-hot select.
- `ADDR_WIDTH`, 8, ROM address width.
- `clk` in 1: the only clock; all logic on the rising edge.
- `reset` in 1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `start` in 1: load command; accepted only in IDLE or DONE.
- `base_addr` in `ADDR_WIDTH`: ROM address of element 0; latched when `start` is accepted.
- `rom_en` out 1: ROM read strobe.
- `rom_addr` out `ADDR_WIDTH`: ROM read address.
- `rom_data` in `DATA_WIDTH`: ROM read data; valid the cycle after `rom_en`.
- `bank_enable` out 1: bank write enable.
- `bank_select` out `BANK_DEPTH`: one-hot bank entry select.
- `bank_data` out `DATA_WIDTH`: byte to write into the bank.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse after the last bank write.

## Operation
- States:
  - IDLE: waits for `start`.
  - FETCH: issues ROM reads.
  - DRAIN: completes the outstanding writes.
  - DONE: one cycle, pulses `done`.
- IDLE→FETCH on `start`=1. Latches `base_addr` and clears element index `idx` to 0.
- FETCH, one cycle per element:
  - `rom_en`=1 and `rom_addr` = `base_addr` + `idx`, truncated to `ADDR_WIDTH`, so addresses wrap modulo 2^`ADDR_WIDTH` (e.g. base 0xFE → FE, FF, 00, …).
  - `idx` increments each cycle.
  - After `idx` = `BANK_DEPTH`-1, go to DRAIN.
- Write stage is a 2-deep registered pipeline tagged with `idx`.
  - In the cycle after the read is issued, `rom_data` is registered into `bank_data`.
  - In the same register stage, `bank_select` is set to `1<<idx` and `bank_enable` is set to 1.
- DRAIN stays until the last write (`idx` = `BANK_DEPTH`-1) has been presented, then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
  - `start`=1 in DONE is accepted and goes directly to FETCH (back-to-back loads).
- `start` in FETCH or DRAIN is ignored; no queuing.
- `bank_select` is all-zero whenever `bank_enable`=0, and is never multi-hot.
- `busy`=1 in FETCH and DRAIN; `busy`=0 in IDLE and DONE.
- Reset (`reset`=0) at any point, including mid-load:
  - Next state is IDLE.
  - All outputs go to 0; the pipeline and `idx` are cleared.
  - No further bank writes occur. Entries already written keep their values, since the bank has its own reset.

## Timing
- `start` sampled at edge E0.
- FETCH occupies cycles 1..`BANK_DEPTH`; the read for element k is in cycle k+1.
- Element k is written to the bank in cycle k+3 (`bank_enable`=1). The bank captures it at the end of that cycle.
- For `BANK_DEPTH`=8:
  - Writes occur in cycles 3..10.
  - `busy`=1 in cycles 1..10.
  - `done`=1 in cycle 11.
- Total latency from start to done: `BANK_DEPTH`+3 cycles.
- Back-to-back loads: with `start` held in the DONE cycle, the next FETCH begins in cycle 12.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values: `rom_en`=0, `rom_addr`=0, `bank_enable`=0, `bank_select`=0, `bank_data`=0, `busy`=0, `done`=0.

## Configuration
- `LOADER_STRIDE_EN` defined:
  - Adds input `stride` (`ADDR_WIDTH`), latched with `base_addr`.
  - `rom_addr` = `base_addr` + `idx`*`stride`, truncated to `ADDR_WIDTH` (wraps). This allows column-major fetch for transposed operands.
  - `stride`=0 reads the same address `BANK_DEPTH` times.
- `LOADER_STRIDE_EN` undefined: port `stride` is absent and the stride is fixed at 1.
- Timing is identical in both configurations.

## Test plan
- Reset, then `start` with `base_addr`=0x10; ROM holds `addr`^0xA5.
  - `rom_addr` = 0x10..0x17 in cycles 1..8.
  - Writes in cycles 3..10 with select 0x01..0x80 and data 0xB5..0xB2.
  - `done` in cycle 11.
- `base_addr`=0xFE: addresses FE, FF, 00..05; bank entries in order.
- `start` pulsed in cycles 4 and 9 of a load: ignored; exactly 8 writes and one `done`.
- `start` held in the DONE cycle with `base_addr`=0x40: second FETCH begins cycle 12, addresses 0x40..0x47, no idle gap.
- `reset`=0 in cycle 6:
  - Outputs are 0 from cycle 7 and `busy`=0.
  - No writes after reset; entries 0..2 were written, entries 3..7 were not.
- With `LOADER_STRIDE_EN` defined, `base_addr`=0x00 and `stride`=8: addresses 0x00, 0x08, …, 0x38.
  - With `stride`=0x30: addresses wrap past 0xFF (…, 0xF0, 0x20, 0x50).
